// File: rtl/potential_update_scheduler.sv
// Sweeps every neuron of a cluster through one shared potential adder per timestep:
// operand load, settle wait, potential write-back, then an optional spike handshake.
module potential_update_scheduler #(
  parameter int NUM_NEURONS = 16,
  parameter int IDX_W       = 4,
  parameter int ADDER_LAT   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             timestep_start,
  output logic             busy,
  output logic             done,
  output logic             overrun,
  output logic [IDX_W-1:0] rd_idx,
  input  logic [31:0]      acc_weight,
  input  logic [31:0]      decayed_pot,
  output logic [31:0]      add_weight,
  output logic [31:0]      add_potential,
  output logic             add_clear,
  input  logic [31:0]      add_final,
  input  logic             add_spike,
  output logic             wb_en,
  output logic [IDX_W-1:0] wb_idx,
  output logic [31:0]      wb_data,
  output logic             spike_valid,
  output logic [IDX_W-1:0] spike_idx,
  input  logic             spike_ready,
  output logic [IDX_W:0]   spike_count
);

  localparam int CNT_W = (ADDER_LAT > 1) ? $clog2(ADDER_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    WRITE,
    EMIT,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        weight_q, weight_d;
  logic [31:0]        pot_q, pot_d;
  logic [31:0]        result_q, result_d;
  logic               spk_q, spk_d;
  logic [IDX_W:0]     count_q, count_d;
  logic               overrun_q, overrun_d;
  logic               last_idx;

  assign last_idx = (idx_q == IDX_W'(NUM_NEURONS - 1));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    weight_d  = weight_q;
    pot_d     = pot_q;
    result_d  = result_q;
    spk_d     = spk_q;
    count_d   = count_q;
    overrun_d = overrun_q;

    // A start that arrives mid-sweep (DONE included) is dropped but remembered.
    if (timestep_start && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (timestep_start) begin
          idx_d     = '0;
          count_d   = '0;
          overrun_d = 1'b0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        weight_d = acc_weight;
        pot_d    = decayed_pot;
        cnt_d    = CNT_W'(ADDER_LAT - 1);
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          result_d = add_final;
          spk_d    = add_spike;
          state_d  = WRITE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WRITE: begin
        if (spk_q) begin
          state_d = EMIT;
        end else if (last_idx) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = LOAD;
        end
      end
      EMIT: begin
        if (spike_ready) begin
          count_d = count_q + (IDX_W + 1)'(1);
          if (last_idx) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = LOAD;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      weight_q  <= '0;
      pot_q     <= '0;
      result_q  <= '0;
      spk_q     <= 1'b0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      weight_q  <= weight_d;
      pot_q     <= pot_d;
      result_q  <= result_d;
      spk_q     <= spk_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign overrun       = overrun_q;
  assign rd_idx        = idx_q;
  assign add_weight    = weight_q;
  assign add_potential = pot_q;
  assign add_clear     = (state_q == LOAD);
  assign wb_en         = (state_q == WRITE);
  assign wb_idx        = idx_q;
  assign wb_data       = result_q;
  assign spike_valid   = (state_q == EMIT);
  assign spike_idx     = idx_q;
  assign spike_count   = count_q;

endmodule

// File: doc/potential_update_scheduler.md
Name: potential_update_scheduler

Overview:
Sequencer that time-multiplexes one shared potential_adder datapath across all NUM_NEURONS neurons of a cluster once per timestep. On each timestep it walks neuron indices in ascending order and, for each neuron:
- fetches the accumulated input weight and the decayed potential,
- drives them into the adder and waits for the floating-point result to settle,
- writes the new potential back,
- hands any spike to the network interface over a valid/ready handshake.

Parameters:
NUM_NEURONS, 16, neurons served per timestep (>=2)
IDX_W, 4, neuron index width, ceil(log2(NUM_NEURONS))
ADDER_LAT, 2, cycles allowed for combinational adder/comparator settling (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
timestep_start  in  1  1-cycle pulse, begins a timestep sweep
busy  out  1  high from accepted start until done cycle inclusive
done  out  1  1-cycle pulse, sweep complete
overrun  out  1  sticky: timestep_start arrived while busy; cleared on next accepted start
rd_idx  out  IDX_W  neuron index for weight/potential memories (combinational read)
acc_weight  in  32  accumulated input weight of rd_idx (IEEE-754)
decayed_pot  in  32  decayed potential of rd_idx (IEEE-754)
add_weight  out  32  registered operand to adder input_weight
add_potential  out  32  registered operand to adder decayed_potential
add_clear  out  1  adder clear, 1 cycle per neuron
add_final  in  32  adder final_potential
add_spike  in  1  adder spike
wb_en  out  1  potential write-back strobe
wb_idx  out  IDX_W  write-back index
wb_data  out  32  write-back potential
spike_valid  out  1  spike event valid
spike_idx  out  IDX_W  spiking neuron index
spike_ready  in  1  network interface accepts spike
spike_count  out  IDX_W+1  spikes emitted this timestep; cleared on accepted start

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs, operand registers, idx, spike_count and overrun go to 0.
  - Applies immediately, including mid-sweep; no write-back or spike completes after reset.
- FSM states: IDLE, LOAD, SETTLE, WRITE, EMIT, DONE.
- IDLE:
  - timestep_start=1 -> idx=0, spike_count=0, overrun=0, busy=1, next LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - rd_idx=idx; add_clear=1 this cycle only.
  - At the edge, add_weight<=acc_weight and add_potential<=decayed_pot; set settle counter=ADDER_LAT-1; next SETTLE.
- SETTLE:
  - Operands held stable.
  - If counter==0, capture add_final into result_reg and add_spike into spk_reg, then next WRITE.
  - Otherwise decrement the counter.
- WRITE:
  - wb_en=1 for exactly 1 cycle, wb_idx=idx, wb_data=result_reg.
  - spk_reg=1 -> EMIT; otherwise go to NEXT.
- EMIT:
  - spike_valid=1, spike_idx=idx; held stable until spike_ready=1.
  - The transfer occurs on the edge where valid&&ready; spike_count increments on that edge, then go to NEXT.
  - spike_ready is ignored outside EMIT.
- NEXT (decision, no extra cycle):
  - idx==NUM_NEURONS-1 -> DONE.
  - Otherwise idx+1 -> LOAD.
- DONE:
  - done=1 and busy=1 for 1 cycle, then IDLE (busy=0).
- Latency:
  - ADDER_LAT+2 cycles per non-spiking neuron.
  - A spiking neuron adds 1 cycle plus any ready-stall cycles.
  - Spike-free sweep: the done cycle is NUM_NEURONS*(ADDER_LAT+2)+1 cycles after the start-accept edge.
- timestep_start while state!=IDLE:
  - Ignored; overrun<=1.
  - In the DONE cycle it is also ignored (sets overrun), so no back-to-back restart.
- Operands: add_weight/add_potential keep their last values between neurons and in IDLE.
- Arithmetic: no arithmetic in this block; the 32-bit values pass through untouched.
- spike_count saturation: cannot exceed NUM_NEURONS; its width guarantees no wrap.

Test Plan:
- Reset mid-sweep: deassert rst_n during SETTLE of idx 5 -> next cycle all outputs 0, state IDLE, no wb_en; a new timestep_start restarts at idx 0.
- No-spike sweep, NUM_NEURONS=4, ADDER_LAT=2, real LIF adder with vth=0x3F800000, all weights 0x3E800000 (0.25), all potentials 0x3E800000:
  - wb_data=0x3F000000 for idx 0..3 at cycles 4, 8, 12, 16.
  - done at cycle 17; spike_count=0.
- Spike with reset, idx 2: weight 0x3F400000 (0.75), potential 0x3F000000 (0.5):
  - wb_data=0x3E800000 (0.25).
  - spike_valid with spike_idx=2; spike_count=1 after the handshake.
- Backpressure: spike_ready low for 5 cycles during EMIT -> spike_valid/spike_idx stable, idx does not advance; sweep extends by exactly 5 cycles.
- Overrun: second timestep_start at sweep cycle 6 -> ignored, sweep unchanged, overrun=1; the next accepted start clears overrun and spike_count.
- Clear strobe: count add_clear pulses over one sweep -> exactly NUM_NEURONS pulses, each in a LOAD cycle, with rd_idx matching the idx written back later.
